polar_encoder: RTL and testbench

- Sequential polar (Arikan) encoder, the transmit-side counterpart of the SC decoder datapath.
- Accepts K information bits serially and inserts zeros at the frozen positions given by a mask; frozen bits use the decoder's convention (1 = frozen).
- Applies log2(N) in-place XOR butterfly stages, x = u·G_N with natural (non-bit-reversed) ordering.
- Streams the N-bit codeword out serially. Used to re-encode decoded frames for checking and to generate bench stimulus.

---
 rtl/polar_pkg.sv | 18 +
 rtl/polar_butterfly_stage.sv | 19 +
 rtl/polar_encoder.sv | 82 ++++++++
 tb/tb_polar_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// polar_pkg: constants, state encoding and code-length helpers shared by the polar encoder and decoder
package polar_pkg;
    localparam int N_MAX     = 512;
    localparam int LOG_N_MAX = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ENC  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    function automatic logic [3:0] clamp_log(input logic [3:0] n_log);
        return (n_log == 4'd0 || n_log > 4'(LOG_N_MAX)) ? 4'(LOG_N_MAX) : n_log;
    endfunction

    function automatic logic [LOG_N_MAX:0] n_from_log(input logic [3:0] n_log);
        return {{LOG_N_MAX{1'b0}}, 1'b1} << clamp_log(n_log);
    endfunction
endpackage

// File: rtl/polar_butterfly_stage.sv
// polar_butterfly_stage: one in-place XOR butterfly layer, vec[j] ^= vec[j + 2^stage] where bit stage of j is 0
module polar_butterfly_stage
    import polar_pkg::*;
(
    input  logic [N_MAX-1:0] vec_in,
    input  logic [3:0]       stage,
    output logic [N_MAX-1:0] vec_out
);
    logic [N_MAX-1:0] partner;
    logic [N_MAX-1:0] pair_low;

    // shifted copy supplies every upper partner; the mask keeps only lower members of each pair
    always_comb begin
        partner  = vec_in >> (32'd1 << stage);
        pair_low = '0;
        for (int j = 0; j < N_MAX; j++) pair_low[j] = ((j >> stage) & 1) == 0;
        vec_out  = vec_in ^ (partner & pair_low);
    end
endmodule

// File: rtl/polar_encoder.sv
// polar_encoder: serial-in/serial-out Arikan encoder with frozen-bit insertion, x = u*G_N in natural order
module polar_encoder
    import polar_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       n_log,
    input  logic [N_MAX-1:0] frozen_mask,
    input  logic             u_valid,
    input  logic             u_bit,
    output logic             u_ready,
    output logic             x_valid,
    output logic             x_bit,
    output logic             x_last,
    input  logic             x_ready,
    output logic             busy
);
    logic [1:0]       state;
    logic [8:0]       idx;
    logic [8:0]       last_idx;
    logic [3:0]       stage;
    logic [3:0]       nlog;
    logic [N_MAX-1:0] vec;
    logic [N_MAX-1:0] mask;
    logic [N_MAX-1:0] vec_enc;

    polar_butterfly_stage u_bf (
        .vec_in (vec),
        .stage  (stage),
        .vec_out(vec_enc)
    );

    // handshakes depend only on registered state, so they are stable for the whole cycle
    always_comb begin
        u_ready = (state == S_LOAD) && !mask[idx];
        x_valid = state == S_OUT;
        x_bit   = (state == S_OUT) ? vec[idx] : 1'b0;
        x_last  = (state == S_OUT) && (idx == last_idx);
        busy    = state != S_IDLE;
    end

    // frame sequencer: load info/frozen bits, run n_log butterfly layers, then stream the codeword
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            stage    <= '0;
            vec      <= '0;
            mask     <= '0;
            nlog     <= '0;
            last_idx <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    nlog     <= clamp_log(n_log);
                    last_idx <= 9'(n_from_log(n_log) - 10'd1);
                    mask     <= frozen_mask;
                    vec      <= '0;
                    idx      <= '0;
                    stage    <= '0;
                    state    <= S_LOAD;
                end
                S_LOAD: if (mask[idx] || u_valid) begin
                    vec[idx] <= u_bit & ~mask[idx];
                    idx      <= (idx == last_idx) ? 9'd0 : idx + 9'd1;
                    state    <= (idx == last_idx) ? S_ENC : S_LOAD;
                end
                S_ENC: begin
                    vec   <= vec_enc;
                    stage <= (stage == nlog - 4'd1) ? 4'd0 : stage + 4'd1;
                    state <= (stage == nlog - 4'd1) ? S_OUT : S_ENC;
                end
                S_OUT: if (x_ready) begin
                    idx   <= (idx == last_idx) ? 9'd0 : idx + 9'd1;
                    state <= (idx == last_idx) ? S_IDLE : S_OUT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: table vectors plus randomized frames checked cycle by cycle against a generator-matrix model
module tb_polar_encoder;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   n_log;
    logic [511:0] frozen_mask;
    logic         u_valid;
    logic         u_bit;
    logic         u_ready;
    logic         x_valid;
    logic         x_bit;
    logic         x_last;
    logic         x_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    polar_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_log      (n_log),
        .frozen_mask(frozen_mask),
        .u_valid    (u_valid),
        .u_bit      (u_bit),
        .u_ready    (u_ready),
        .x_valid    (x_valid),
        .x_bit      (x_bit),
        .x_last     (x_last),
        .x_ready    (x_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nl;
        logic [7:0] mask;
        logic [7:0] info;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // x[c] = XOR of u[r] over all rows r whose bit set contains c (G_N = F^{(x)n}, F = [1 0; 1 1])
    function automatic logic [511:0] ref_enc(input logic [511:0] u, input int nn);
        logic [511:0] x = '0;
        for (int c = 0; c < nn; c++)
            for (int r = 0; r < nn; r++)
                if ((r & c) == c) x[c] = x[c] ^ u[r];
        return x;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // called at a negedge; returns at the negedge where the block is back in IDLE (or just after an abort reset)
    task automatic do_frame(input logic [3:0] nl, input logic [511:0] fm, input logic [511:0] info,
                            input int pv, input int px, input bit stray, input int abort_at,
                            output logic [511:0] got, output int lat);
        int n, nn, phase, li, ptr, ec, oi, cyc;
        logic [511:0] u, x;
        bit uv, xr;
        n = (nl == 0 || nl > 9) ? 9 : int'(nl);
        nn = 1 << n;
        u = '0; x = '0; got = '0; lat = -1;
        li = 0; ptr = 0; ec = 0; oi = 0; cyc = 0; phase = 0;
        start = 1'b1; n_log = nl; frozen_mask = fm; u_valid = 1'b0; x_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; n_log = 4'($urandom); frozen_mask = rand512();
        while (phase != 3) begin
            cyc++;
            if (cyc == abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_xvalid", x_valid, 0);
                chk("abort_uready", u_ready, 0);
                chk("abort_xbit", x_bit, 0);
                chk("abort_xlast", x_last, 0);
                return;
            end
            if (cyc > 20000) begin
                checks++;
                errors++;
                $display("FAIL timeout frame not finished after %0d cycles, phase %0d", cyc, phase);
                break;
            end
            if (x_valid && lat < 0) lat = cyc;
            start = stray && ($urandom_range(0, 9) == 0);
            if (phase == 0) begin
                chk("u_ready", u_ready, !fm[li]);
                chk("load_busy", busy, 1);
                chk("load_xvalid", x_valid, 0);
                uv = $urandom_range(0, 99) < pv;
                u_valid = uv;
                x_ready = 1'($urandom);
                if (fm[li]) begin
                    u_bit = 1'($urandom);
                    li++;
                end else if (uv) begin
                    u_bit = info[ptr];
                    u[li] = info[ptr];
                    ptr++;
                    li++;
                end else u_bit = 1'($urandom);
                if (li == nn) phase = 1;
            end else if (phase == 1) begin
                chk("enc_busy", busy, 1);
                chk("enc_xvalid", x_valid, 0);
                chk("enc_uready", u_ready, 0);
                u_valid = 1'($urandom);
                ec++;
                if (ec == n) begin
                    phase = 2;
                    x = ref_enc(u, nn);
                end
            end else begin
                chk("x_valid", x_valid, 1);
                chk("x_bit", x_bit, x[oi]);
                chk("x_last", x_last, oi == nn - 1);
                chk("out_uready", u_ready, 0);
                got[oi] = x_bit;
                xr = $urandom_range(0, 99) < px;
                x_ready = xr;
                u_valid = 1'($urandom);
                if (xr) begin
                    if (oi == nn - 1) phase = 3;
                    else oi++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0; u_valid = 1'b0; x_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_xvalid", x_valid, 0);
    endtask

    initial begin
        logic [511:0] got, fm;
        int lat;
        tbl[0] = '{4'd1, 8'h00, 8'h01, 8'h01};
        tbl[1] = '{4'd1, 8'h00, 8'h02, 8'h03};
        tbl[2] = '{4'd2, 8'h00, 8'h08, 8'h0F};
        tbl[3] = '{4'd2, 8'h00, 8'h01, 8'h01};
        tbl[4] = '{4'd2, 8'h03, 8'h03, 8'h0A};
        tbl[5] = '{4'd2, 8'h0F, 8'h00, 8'h00};
        tbl[6] = '{4'd3, 8'h0F, 8'h01, 8'h11};

        rst = 1'b1; start = 1'b0; n_log = '0; frozen_mask = '0;
        u_valid = 1'b0; u_bit = 1'b0; x_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_xvalid", x_valid, 0);
        chk("rst_uready", u_ready, 0);
        chk("rst_xbit", x_bit, 0);
        chk("rst_xlast", x_last, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            fm = rand512();
            for (int b = 0; b < (1 << tbl[i].nl); b++) fm[b] = tbl[i].mask[b];
            do_frame(tbl[i].nl, fm, {504'd0, tbl[i].info}, 100, 100, 1'b0, 0, got, lat);
            chk($sformatf("tbl%0d_x", i), {24'd0, got[7:0]}, {24'd0, tbl[i].exp});
            if (i == 2) chk("latency_n4", lat, 7);
            @(negedge clk);
        end

        do_frame(4'd9, rand512(), rand512(), 70, 60, 1'b1, 0, got, lat);
        @(negedge clk);
        do_frame(4'd0, rand512(), rand512(), 60, 70, 1'b1, 0, got, lat);
        do_frame(4'd12, rand512(), rand512(), 80, 50, 1'b1, 0, got, lat);
        chk("nlog12_latency_min", lat >= 1 + 512 + 9, 1);

        do_frame(4'd9, rand512(), rand512(), 80, 100, 1'b0, 5, got, lat);
        do_frame(4'd2, '0, 512'h1, 100, 100, 1'b0, 0, got, lat);
        chk("after_load_abort", got[3:0], 4'h1);
        @(negedge clk);
        do_frame(4'd2, '0, 512'h8, 100, 100, 1'b0, 8, got, lat);
        do_frame(4'd2, '0, 512'h1, 100, 100, 1'b0, 0, got, lat);
        chk("after_out_abort", got[3:0], 4'h1);

        do_frame(4'd3, rand512(), rand512(), 100, 100, 1'b0, 0, got, lat);
        do_frame(4'd3, '0, 512'h80, 100, 100, 1'b0, 0, got, lat);
        chk("b2b_x", got[7:0], 8'hFF);
        chk("b2b_latency", lat, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
